// File: rtl/pixel_map_pkg.sv
// Shared pixel-map constants, command opcodes and palette indices for the
// map writer and the display blocks that read the same BRAM.
package pixel_map_pkg;

  localparam int MAP_WIDTH   = 64;
  localparam int MAP_HEIGHT  = 62;
  localparam int ADDR_WIDTH  = 12;
  localparam int COLOR_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_FILL_RECT  = 2'd0,
    OP_WRITE_CELL = 2'd1,
    OP_CLEAR_ALL  = 2'd2,
    OP_RSVD       = 2'd3
  } pm_op_t;

  localparam logic [COLOR_WIDTH-1:0] BLACK   = 4'd0;
  localparam logic [COLOR_WIDTH-1:0] RED     = 4'd1;
  localparam logic [COLOR_WIDTH-1:0] GREEN   = 4'd2;
  localparam logic [COLOR_WIDTH-1:0] BLUE    = 4'd3;
  localparam logic [COLOR_WIDTH-1:0] YELLOW  = 4'd4;
  localparam logic [COLOR_WIDTH-1:0] CYAN    = 4'd5;
  localparam logic [COLOR_WIDTH-1:0] MAGENTA = 4'd6;
  localparam logic [COLOR_WIDTH-1:0] GREY    = 4'd7;
  localparam logic [COLOR_WIDTH-1:0] WHITE   = 4'd8;

  // Rectangle operands after opcode decode, before clipping.
  typedef struct packed {
    logic [5:0]             col;
    logic [5:0]             row;
    logic [6:0]             w;
    logic [6:0]             h;
    logic [COLOR_WIDTH-1:0] color;
  } pm_rect_t;

  function automatic logic [6:0] min7(input logic [6:0] a, input logic [6:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/rect_raster_counter.sv
// Row-major cell walker over a clipped rectangle. State is the cell currently
// being written; outputs give the following cell and whether this one is last.
module rect_raster_counter #(
  parameter int COORD_W = 6,
  parameter int DIM_W   = 7
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               adv_i,
  input  logic [COORD_W-1:0] col_i,
  input  logic [COORD_W-1:0] row_i,
  input  logic [DIM_W-1:0]   w_i,
  input  logic [DIM_W-1:0]   h_i,
  output logic [COORD_W-1:0] nxt_col_o,
  output logic [COORD_W-1:0] nxt_row_o,
  output logic               last_o
);

  logic [COORD_W-1:0] col_q, row_q, col_start_q, col_end_q, row_end_q;
  logic               wrap;

  always_comb begin
    wrap      = (col_q == col_end_q);
    nxt_col_o = wrap ? col_start_q : col_q + COORD_W'(1);
    nxt_row_o = wrap ? row_q + COORD_W'(1) : row_q;
    last_o    = wrap && (row_q == row_end_q);
  end

  // w_i/h_i are non-zero and pre-clipped, so the end coordinates fit COORD_W.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q       <= '0;
      row_q       <= '0;
      col_start_q <= '0;
      col_end_q   <= '0;
      row_end_q   <= '0;
    end else if (load_i) begin
      col_q       <= col_i;
      row_q       <= row_i;
      col_start_q <= col_i;
      col_end_q   <= COORD_W'({1'b0, col_i} + w_i - DIM_W'(1));
      row_end_q   <= COORD_W'({1'b0, row_i} + h_i - DIM_W'(1));
    end else if (adv_i) begin
      col_q <= nxt_col_o;
      row_q <= nxt_row_o;
    end
  end

endmodule

// File: rtl/pixel_map_writer.sv
// Pixel-map write port: takes fill/cell/clear commands and streams one
// registered BRAM port-A write per clock in raster order.
module pixel_map_writer
  import pixel_map_pkg::*;
#(
  parameter int MAP_WIDTH   = pixel_map_pkg::MAP_WIDTH,
  parameter int MAP_HEIGHT  = pixel_map_pkg::MAP_HEIGHT,
  parameter int ADDR_WIDTH  = pixel_map_pkg::ADDR_WIDTH,
  parameter int COLOR_WIDTH = pixel_map_pkg::COLOR_WIDTH
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   cmd_valid_in,
  output logic                   cmd_ready_out,
  input  logic [1:0]             cmd_op_in,
  input  logic [5:0]             cmd_col_in,
  input  logic [5:0]             cmd_row_in,
  input  logic [6:0]             cmd_w_in,
  input  logic [6:0]             cmd_h_in,
  input  logic [COLOR_WIDTH-1:0] cmd_color_in,
  output logic                   wea_out,
  output logic [ADDR_WIDTH-1:0]  addra_out,
  output logic [COLOR_WIDTH-1:0] dina_out,
  output logic                   busy_out,
  output logic                   done_out
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam int         CSH     = $clog2(MAP_WIDTH);
  localparam logic [6:0] MW7     = 7'(MAP_WIDTH);
  localparam logic [6:0] MH7     = 7'(MAP_HEIGHT);

  logic [0:0]             state_q, state_d;
  logic                   wea_q, wea_d, done_q, done_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d, start_addr, nxt_addr;
  logic [COLOR_WIDTH-1:0] din_q, din_d;
  pm_rect_t               r;
  logic [6:0]             w_room, h_room, w_eff, h_eff;
  logic                   accept, empty, load, adv, last;
  logic [5:0]             nxt_col, nxt_row;

  always_comb begin
    r = '{col: cmd_col_in, row: cmd_row_in, w: cmd_w_in, h: cmd_h_in, color: cmd_color_in};
    case (pm_op_t'(cmd_op_in))
      OP_FILL_RECT:  ;
      OP_WRITE_CELL: begin r.w = 7'd1; r.h = 7'd1; end
      OP_CLEAR_ALL:  r = '{col: 6'd0, row: 6'd0, w: MW7, h: MH7, color: '0};
      default:       begin r.w = 7'd0; r.h = 7'd0; end
    endcase
    // Clip to the map so the raster never walks past the last address.
    w_room = MW7 - {1'b0, r.col};
    h_room = ({1'b0, r.row} >= MH7) ? 7'd0 : MH7 - {1'b0, r.row};
    w_eff  = min7(r.w, w_room);
    h_eff  = min7(r.h, h_room);
    empty  = (w_eff == 7'd0) || (h_eff == 7'd0);
    start_addr = (ADDR_WIDTH'(r.row) << CSH) + ADDR_WIDTH'(r.col);
    nxt_addr   = (ADDR_WIDTH'(nxt_row) << CSH) + ADDR_WIDTH'(nxt_col);
  end

  assign cmd_ready_out = (state_q == ST_IDLE);
  assign busy_out      = !cmd_ready_out;
  assign accept        = cmd_valid_in && cmd_ready_out;

  always_comb begin
    state_d = state_q;
    wea_d   = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    done_d  = 1'b0;
    load    = 1'b0;
    adv     = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        if (empty) begin
          done_d = 1'b1;
        end else begin
          state_d = ST_RUN;
          load    = 1'b1;
          wea_d   = 1'b1;
          addr_d  = start_addr;
          din_d   = r.color;
        end
      end
      default: if (last) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        adv    = 1'b1;
        wea_d  = 1'b1;
        addr_d = nxt_addr;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      wea_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wea_q   <= wea_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      done_q  <= done_d;
    end
  end

  rect_raster_counter #(.COORD_W(6), .DIM_W(7)) u_raster (
    .clk_i     (clk_in),
    .rst_ni    (rst_n_in),
    .load_i    (load),
    .adv_i     (adv),
    .col_i     (r.col),
    .row_i     (r.row),
    .w_i       (w_eff),
    .h_i       (h_eff),
    .nxt_col_o (nxt_col),
    .nxt_row_o (nxt_row),
    .last_o    (last)
  );

  assign wea_out   = wea_q;
  assign addra_out = addr_q;
  assign dina_out  = din_q;
  assign done_out  = done_q;

endmodule

// File: tb/tb_pixel_map_writer.sv
// Scoreboard bench for pixel_map_writer: directed commands push expected
// writes/done pulses with cycle stamps; a negedge monitor pops and compares.
module tb_pixel_map_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [1:0]  op = '0;
  logic [5:0]  col = '0, row = '0;
  logic [6:0]  w = '0, h = '0;
  logic [3:0]  color = '0;
  logic        wea, busy, done;
  logic [11:0] addra;
  logic [3:0]  dina;

  typedef struct {
    bit is_done;
    int cyc;
    int addr;
    int data;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pixel_map_writer dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .cmd_valid_in  (valid),
    .cmd_ready_out (ready),
    .cmd_op_in     (op),
    .cmd_col_in    (col),
    .cmd_row_in    (row),
    .cmd_w_in      (w),
    .cmd_h_in      (h),
    .cmd_color_in  (color),
    .wea_out       (wea),
    .addra_out     (addra),
    .dina_out      (dina),
    .busy_out      (busy),
    .done_out      (done)
  );

  // Monitor: every write or done pulse must match the head of the queue.
  always @(negedge clk) begin
    ev_t e;
    if (wea) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected: cyc=%0d addr=%0d data=%0d, required none", cyc, addra, dina);
      end else begin
        e = q.pop_front();
        if (e.is_done || e.cyc != cyc || e.addr != int'(addra) || e.data != int'(dina)) begin
          failures++;
          $display("FAIL write: got cyc=%0d addr=%0d data=%0d, required done=%0d cyc=%0d addr=%0d data=%0d",
                   cyc, addra, dina, e.is_done, e.cyc, e.addr, e.data);
        end
      end
    end
    if (done) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected: cyc=%0d, required none", cyc);
      end else begin
        e = q.pop_front();
        if (!e.is_done || e.cyc != cyc) begin
          failures++;
          $display("FAIL done: got cyc=%0d, required done=%0d cyc=%0d addr=%0d", cyc, e.is_done, e.cyc, e.addr);
        end
      end
    end
  end

  task automatic push_wr(input int c, input int a, input int d);
    q.push_back('{is_done: 1'b0, cyc: c, addr: a, data: d});
  endtask

  task automatic push_done(input int c);
    q.push_back('{is_done: 1'b1, cyc: c, addr: 0, data: 0});
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Present a command, wait for acceptance, return acceptance cycle N.
  task automatic issue(input logic [1:0] o, input logic [5:0] c, input logic [5:0] r,
                       input logic [6:0] ww, input logic [6:0] hh, input logic [3:0] k,
                       output int n);
    int t;
    @(negedge clk);
    valid = 1'b1; op = o; col = c; row = r; w = ww; h = hh; color = k;
    t = 0;
    while (!ready && t < 6000) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: ready=%0d, required 1", ready);
    end
    n = cyc;
    @(posedge clk);
    #1;
    valid = 1'b0; op = 2'd2; col = 6'h2a; row = 6'h15; w = 7'h7f; h = 7'h7f; color = 4'hf;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (q.size() != 0 && t < 8000) begin
      @(negedge clk);
      t++;
    end
    check(name, q.size(), 0);
    q.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n, n2;
    int a2[6] = '{194, 195, 196, 258, 259, 260};

    // 1: reset, then idle
    repeat (3) @(negedge clk);
    check("reset_wea", int'(wea), 0);
    check("reset_ready", int'(ready), 1);
    check("reset_done", int'(done), 0);
    check("reset_addr", int'(addra), 0);
    check("reset_din", int'(dina), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wea || !ready || done || busy) check("idle", {wea, ready, done, busy}, 4'b0100);
    end
    check("idle_end_ready", int'(ready), 1);

    // 2: FILL 3x2 at (2,3)
    issue(2'd0, 6'd2, 6'd3, 7'd3, 7'd2, 4'd5, n);
    for (int i = 0; i < 6; i++) push_wr(n + 1 + i, a2[i], 5);
    push_done(n + 7);
    wait_drain("drain_fill");

    // 3: clipped fill at bottom-right corner
    issue(2'd0, 6'd62, 6'd61, 7'd4, 7'd4, 4'd1, n);
    push_wr(n + 1, 3966, 1);
    push_wr(n + 2, 3967, 1);
    push_done(n + 3);
    wait_drain("drain_clip");

    // 4: single cell, w/h operands ignored
    issue(2'd1, 6'd63, 6'd0, 7'd0, 7'd0, 4'd8, n);
    push_wr(n + 1, 63, 8);
    push_done(n + 2);
    wait_drain("drain_cell");

    // zero-cell cases: reserved op, row off the map, zero width
    issue(2'd3, 6'd1, 6'd1, 7'd4, 7'd4, 4'd2, n);
    push_done(n + 1);
    wait_drain("drain_rsvd");
    issue(2'd0, 6'd0, 6'd62, 7'd5, 7'd5, 4'd2, n);
    push_done(n + 1);
    wait_drain("drain_row_off");
    issue(2'd0, 6'd0, 6'd0, 7'd0, 7'd3, 4'd2, n);
    push_done(n + 1);
    wait_drain("drain_w0");

    // wide fill on last row, clipped to 64 cells
    issue(2'd0, 6'd0, 6'd61, 7'd100, 7'd1, 4'd3, n);
    for (int i = 0; i < 64; i++) push_wr(n + 1 + i, 3904 + i, 3);
    push_done(n + 65);
    wait_drain("drain_wide");

    // 5: CLEAR_ALL, next command held valid until done
    issue(2'd2, 6'd9, 6'd9, 7'd9, 7'd9, 4'd9, n);
    for (int i = 0; i < 3968; i++) push_wr(n + 1 + i, i, 0);
    push_done(n + 3969);
    repeat (100) @(negedge clk);
    check("busy_mid_clear", int'(busy), 1);
    check("ready_mid_clear", int'(ready), 0);
    issue(2'd1, 6'd5, 6'd1, 7'd0, 7'd0, 4'd7, n2);
    check("accept_on_done_cycle", n2, n + 3969);
    push_wr(n2 + 1, 69, 7);
    push_done(n2 + 2);
    wait_drain("drain_clear");

    // 6: reset during the 10th write of CLEAR_ALL
    issue(2'd2, 6'd0, 6'd0, 7'd0, 7'd0, 4'd0, n);
    for (int i = 0; i < 9; i++) push_wr(n + 1 + i, i, 0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_wea", int'(wea), 0);
    check("abort_done", int'(done), 0);
    check("abort_ready", int'(ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_drain("drain_abort");
    issue(2'd0, 6'd4, 6'd4, 7'd0, 7'd2, 4'd6, n);
    push_done(n + 1);
    wait_drain("drain_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
